display_arbiter: RTL and testbench

//  Time-shares the 4-digit seven-segment display between two requesters, e.g. the switch readout and miner status.

---
 rtl/display_arbiter.sv | 156 +++++++++++++++
 tb/tb_display_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/display_arbiter.sv
// Round-robin owner of the 4-digit seven-segment display with minimum hold time and scan drive.
// Optional LEADING_ZERO_BLANK_EN: blank leading zero digits (3..1) while the display is owned.
module display_arbiter #(
    parameter int REFRESH_DIV = 100000,
    parameter int HOLD_CYCLES = 100000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [15:0] data0,
    input  logic [15:0] data1,
    output logic [1:0]  grant,
    output logic [1:0]  refresh_count,
    output logic [3:0]  anode,
    output logic [3:0]  digit
);

    localparam int PRE_W  = $clog2(REFRESH_DIV);
    localparam int HOLD_W = $clog2(HOLD_CYCLES);
    localparam logic [PRE_W-1:0]  PRE_MAX  = PRE_W'(REFRESH_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [HOLD_W-1:0]  hold_count_q, hold_count_d;
    logic               last_q, last_d;
    logic [15:0]        display_value_q, display_value_d;
    logic [PRE_W-1:0]   prescaler_q, prescaler_d;
    logic [1:0]         refresh_count_q, refresh_count_d;
    logic [1:0]         grant_q, grant_d;
    logic               tick;
    logic               hold_done;
    logic               owned;
    logic [3:0]         scan_onehot;
    logic [3:0]         blank;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= IDLE;
            hold_count_q    <= '0;
            last_q          <= 1'b1;
            display_value_q <= '0;
            prescaler_q     <= '0;
            refresh_count_q <= '0;
            grant_q         <= '0;
        end else begin
            state_q         <= state_d;
            hold_count_q    <= hold_count_d;
            last_q          <= last_d;
            display_value_q <= display_value_d;
            prescaler_q     <= prescaler_d;
            refresh_count_q <= refresh_count_d;
            grant_q         <= grant_d;
        end
    end

    // Scan prescaler runs regardless of ownership.
    always_comb begin
        tick            = (prescaler_q == PRE_MAX);
        prescaler_d     = tick ? '0 : prescaler_q + PRE_W'(1);
        refresh_count_d = refresh_count_q;
        if (tick) begin
            refresh_count_d = refresh_count_q + 2'd1;
        end
    end

    always_comb begin
        state_d         = state_q;
        hold_count_d    = hold_count_q;
        last_d          = last_q;
        display_value_d = display_value_q;
        hold_done       = (hold_count_q == HOLD_MAX);

        case (state_q)
            IDLE: begin
                case (req)
                    2'b01:   state_d = OWN0;
                    2'b10:   state_d = OWN1;
                    2'b11:   state_d = last_q ? OWN0 : OWN1;
                    default: state_d = IDLE;
                endcase
            end
            OWN0: begin
                if (!hold_done) begin
                    hold_count_d = hold_count_q + HOLD_W'(1);
                end else if (req[1]) begin
                    state_d = OWN1;
                end else if (!req[0]) begin
                    state_d = IDLE;
                end
                if (req[0]) begin
                    display_value_d = data0;
                end
            end
            OWN1: begin
                if (!hold_done) begin
                    hold_count_d = hold_count_q + HOLD_W'(1);
                end else if (req[0]) begin
                    state_d = OWN0;
                end else if (!req[1]) begin
                    state_d = IDLE;
                end
                if (req[1]) begin
                    display_value_d = data1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Entering a new owner restarts the hold window and captures that owner's value.
        if (state_d != state_q) begin
            if (state_d == OWN0) begin
                hold_count_d    = '0;
                last_d          = 1'b0;
                display_value_d = data0;
            end else if (state_d == OWN1) begin
                hold_count_d    = '0;
                last_d          = 1'b1;
                display_value_d = data1;
            end
        end

        grant_d = {state_d == OWN1, state_d == OWN0};
    end

`ifdef LEADING_ZERO_BLANK_EN
    always_comb begin
        blank[3] = (display_value_q[15:12] == 4'd0);
        blank[2] = blank[3] && (display_value_q[11:8] == 4'd0);
        blank[1] = blank[2] && (display_value_q[7:4] == 4'd0);
        blank[0] = 1'b0;
    end
`else
    assign blank = 4'b0000;
`endif

    always_comb begin
        owned       = (state_q != IDLE);
        scan_onehot = 4'b0001 << refresh_count_q;
        anode       = 4'hF;
        digit       = 4'd0;
        if (owned) begin
            anode = ~(scan_onehot & ~blank);
            digit = display_value_q[{refresh_count_q, 2'b00} +: 4];
        end
    end

    assign grant         = grant_q;
    assign refresh_count = refresh_count_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter with REFRESH_DIV=4, HOLD_CYCLES=8.
module tb_display_arbiter;

  localparam int REFRESH_DIV = 4;
  localparam int HOLD_CYCLES = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req = 2'b00;
  logic [15:0] data0 = 16'h0000;
  logic [15:0] data1 = 16'hABCD;
  logic [1:0]  grant;
  logic [1:0]  refresh_count;
  logic [3:0]  anode;
  logic [3:0]  digit;

  int vectors = 0;
  int miscompares = 0;
  int n_edges = 0;
  logic [7:0] exp_q[$];

  logic [3:0] an_tab [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
  logic [3:0] dg_1234 [4] = '{4'h4, 4'h3, 4'h2, 4'h1};
  logic [3:0] dg_0050 [4] = '{4'h0, 4'h5, 4'h0, 4'h0};
`ifdef LEADING_ZERO_BLANK_EN
  logic [3:0] an_0050 [4] = '{4'hE, 4'hD, 4'hF, 4'hF};
`else
  logic [3:0] an_0050 [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
`endif

  display_arbiter #(
    .REFRESH_DIV(REFRESH_DIV),
    .HOLD_CYCLES(HOLD_CYCLES)
  ) dut (
    .clock(clock),
    .reset(reset),
    .req(req),
    .data0(data0),
    .data1(data1),
    .grant(grant),
    .refresh_count(refresh_count),
    .anode(anode),
    .digit(digit)
  );

  // clock/reset block
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n clock edges; n_edges counts non-reset edges since the last reset edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      if (reset) n_edges = 0;
      else n_edges++;
      #1;
    end
  endtask

  function automatic logic [1:0] exp_rc();
    return 2'((n_edges / 4) % 4);
  endfunction

  function automatic logic [3:0] nib(input logic [15:0] v, input logic [1:0] k);
    return v[{k, 2'b00} +: 4];
  endfunction

  task automatic apply_reset(input logic [1:0] r);
    req = r;
    reset = 1'b1;
    step(2);
    check("rst_grant", 16'(grant), 16'h0);
    check("rst_anode", 16'(anode), 16'hF);
    check("rst_rc", 16'(refresh_count), 16'h0);
    check("rst_digit", 16'(digit), 16'h0);
    reset = 1'b0;
    check("release_grant", 16'(grant), 16'h0);
  endtask

  initial begin
    logic [7:0] e;
    logic [1:0] rc;

    // T1 + T3: contention from reset
    data0 = 16'h1234;
    data1 = 16'hABCD;
    apply_reset(2'b11);
    step(1);
    for (int i = 0; i < 8; i++) begin
      check("t3_own0", 16'(grant), 16'h1);
      if (i == 3) check("t3_digit0", 16'(digit), 16'(nib(16'h1234, exp_rc())));
      step(1);
    end
    for (int i = 0; i < 8; i++) begin
      check("t3_own1", 16'(grant), 16'h2);
      if (i == 0) begin
        check("t3_digit1", 16'(digit), 16'(nib(16'hABCD, exp_rc())));
        check("t3_rc", 16'(refresh_count), 16'(exp_rc()));
      end
      step(1);
    end
    check("t3_back0", 16'(grant), 16'h1);

    // reset while OWN0 (last=0): first tie after reset must still go to requester 0
    reset = 1'b1;
    step(1);
    check("t3r_grant", 16'(grant), 16'h0);
    check("t3r_rc", 16'(refresh_count), 16'h0);
    reset = 1'b0;
    step(1);
    check("t3r_tie", 16'(grant), 16'h1);

    // T2: single owner scan, then saturated hold hands off immediately
    data0 = 16'h1234;
    apply_reset(2'b01);
    step(1);
    check("t2_grant", 16'(grant), 16'h1);
    for (int s = 0; s < 20; s++) begin
      rc = 2'(((n_edges + s) / 4) % 4);
      exp_q.push_back({an_tab[rc], dg_1234[rc]});
    end
    for (int s = 0; s < 20; s++) begin
      e = exp_q.pop_front();
      check("t2_anode", 16'(anode), 16'(e[7:4]));
      check("t2_digit", 16'(digit), 16'(e[3:0]));
      if (s == 19) check("t2_hold_grant", 16'(grant), 16'h1);
      step(1);
    end
    req = 2'b11;
    step(1);
    check("t2_handoff", 16'(grant), 16'h2);
    check("t2_digit1", 16'(digit), 16'(nib(16'hABCD, exp_rc())));

    // T4: early release does not shorten the grant
    data0 = 16'h5678;
    apply_reset(2'b01);
    step(3);
    req = 2'b00;
    data0 = 16'h9999;
    check("t4_c3", 16'(grant), 16'h1);
    for (int i = 4; i <= 8; i++) begin
      step(1);
      check("t4_hold", 16'(grant), 16'h1);
      check("t4_digit", 16'(digit), 16'(nib(16'h5678, exp_rc())));
    end
    step(1);
    check("t4_idle_grant", 16'(grant), 16'h0);
    check("t4_idle_anode", 16'(anode), 16'hF);
    check("t4_idle_digit", 16'(digit), 16'h0);
    step(2);
    check("t4_idle_stay", 16'(grant), 16'h0);
    req = 2'b10;
    step(1);
    check("t4_own1", 16'(grant), 16'h2);
    check("t4_own1_digit", 16'(digit), 16'(nib(16'hABCD, exp_rc())));

    // T5: reset during OWN1
    step(3);
    reset = 1'b1;
    step(1);
    check("t5_grant", 16'(grant), 16'h0);
    check("t5_rc", 16'(refresh_count), 16'h0);
    check("t5_anode", 16'(anode), 16'hF);
    reset = 1'b0;
    req = 2'b11;
    step(1);
    check("t5_tie", 16'(grant), 16'h1);

    // T6: leading zeros
    data0 = 16'h0050;
    apply_reset(2'b01);
    step(1);
    for (int s = 0; s < 16; s++) begin
      rc = exp_rc();
      check("t6_anode", 16'(anode), 16'(an_0050[rc]));
      check("t6_digit", 16'(digit), 16'(dg_0050[rc]));
      step(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
